nrzi_rx_deser: RTL

Parametrised USB-style receive front end. It NRZI-decodes a serial line sample stream and detects the SYNC field. It removes stuffed bits with a configurable run length and packs the payload LSB-first into DATA_W-bit words with start/end-of-packet framing and per-packet error pulses. It sits between the line sampler, which delivers one i_nrzi bit per i_valid cycle, and the packet/PID parser.

---
 rtl/nrzi_rx_pkg.sv | 22 ++
 rtl/nrzi_rx_deser_if.sv | 36 +++
 rtl/nrzi_bit_decode.sv | 30 +++
 rtl/nrzi_rx_deser.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/nrzi_rx_pkg.sv
// Shared types and constants for the NRZI receive deserializer.
package nrzi_rx_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_STUFF_LEN = 6;
    localparam int DEF_SYNC_LEN  = 8;

    localparam logic J_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        ABORT
    } state_t;

    typedef struct packed {
        logic d;
        logic dv;
    } dec_t;

endpackage

// File: rtl/nrzi_rx_deser_if.sv
// Output bundle from the receive deserializer to the packet parser.
interface nrzi_rx_deser_if
    import nrzi_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_sop;
    logic              o_eop;
    logic              o_stuff_err;
    logic              o_sync_err;
    logic              o_align_err;

    modport master (
        output o_data,
        output o_valid,
        output o_sop,
        output o_eop,
        output o_stuff_err,
        output o_sync_err,
        output o_align_err
    );

    modport slave (
        input o_data,
        input o_valid,
        input o_sop,
        input o_eop,
        input o_stuff_err,
        input o_sync_err,
        input o_align_err
    );

endinterface

// File: rtl/nrzi_bit_decode.sv
// Stage 1: NRZI decode; a repeated line level is a 1, a transition a 0.
module nrzi_bit_decode
    import nrzi_rx_pkg::*;
(
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_nrzi,
    input  logic i_valid,
    output dec_t o_dec
);

    logic prev;

    // prev returns to J between packets so each packet decodes from idle
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prev  <= J_LEVEL;
            o_dec <= '0;
        end else if (i_valid) begin
            prev     <= i_nrzi;
            o_dec.d  <= (i_nrzi == prev);
            o_dec.dv <= 1'b1;
        end else begin
            prev     <= J_LEVEL;
            o_dec.d  <= 1'b0;
            o_dec.dv <= 1'b0;
        end
    end

endmodule

// File: rtl/nrzi_rx_deser.sv
// Stage 2: SYNC detect, bit unstuffing and LSB-first word packing.
module nrzi_rx_deser
    import nrzi_rx_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STUFF_LEN = DEF_STUFF_LEN,
    parameter int SYNC_LEN  = DEF_SYNC_LEN
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_nrzi,
    input  logic i_valid,
    nrzi_rx_deser_if.master rx
);

    localparam int RW = $clog2(STUFF_LEN + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int ZW = $clog2(SYNC_LEN);

    localparam logic [RW-1:0] RUN_MAX = RW'(STUFF_LEN);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_W - 1);
    localparam logic [ZW-1:0] Z_LAST  = ZW'(SYNC_LEN - 1);

    dec_t dec;

    nrzi_bit_decode u_dec (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_nrzi (i_nrzi),
        .i_valid(i_valid),
        .o_dec  (dec)
    );

    state_t            state, state_n;
    logic [ZW-1:0]     zcnt, zcnt_n;
    logic [RW-1:0]     run, run_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] data, data_n;
    logic              first, first_n;
    logic              valid_n, sop_n, eop_n;
    logic              stuff_n, sync_n, align_n;

    always_comb begin
        state_n  = state;
        zcnt_n   = zcnt;
        run_n    = run;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        data_n   = data;
        first_n  = first;
        valid_n  = 1'b0;
        sop_n    = 1'b0;
        eop_n    = 1'b0;
        stuff_n  = 1'b0;
        sync_n   = 1'b0;
        align_n  = 1'b0;
        unique case (state)
            IDLE: begin
                zcnt_n = '0;
                // first bit of a packet is already a SYNC bit
                if (dec.dv) begin
                    if (!dec.d) begin
                        zcnt_n  = ZW'(1);
                        state_n = SYNC;
                    end else begin
                        sync_n  = 1'b1;
                        state_n = ABORT;
                    end
                end
            end
            SYNC: begin
                if (!dec.dv) begin
                    sync_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    unique case (1'b1)
                        (!dec.d && zcnt != Z_LAST): begin
                            zcnt_n = zcnt + ZW'(1);
                        end
                        (dec.d && zcnt == Z_LAST): begin
                            run_n    = RW'(1);
                            bitcnt_n = '0;
                            first_n  = 1'b1;
                            state_n  = DATA;
                        end
                        default: begin
                            sync_n  = 1'b1;
                            state_n = ABORT;
                        end
                    endcase
                end
            end
            DATA: begin
                if (!dec.dv) begin
                    eop_n   = 1'b1;
                    align_n = (bitcnt != '0);
                    state_n = IDLE;
                end else if (run == RUN_MAX) begin
                    if (dec.d) begin
                        stuff_n = 1'b1;
                        state_n = ABORT;
                    end else begin
                        run_n = '0;
                    end
                end else begin
                    run_n   = dec.d ? run + RW'(1) : '0;
                    shreg_n = {dec.d, shreg[DATA_W-1:1]};
                    if (bitcnt == B_LAST) begin
                        data_n   = shreg_n;
                        valid_n  = 1'b1;
                        sop_n    = first;
                        first_n  = 1'b0;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            ABORT: begin
                if (!dec.dv) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= IDLE;
            zcnt           <= '0;
            run            <= '0;
            bitcnt         <= '0;
            shreg          <= '0;
            data           <= '0;
            first          <= 1'b0;
            rx.o_valid     <= 1'b0;
            rx.o_sop       <= 1'b0;
            rx.o_eop       <= 1'b0;
            rx.o_stuff_err <= 1'b0;
            rx.o_sync_err  <= 1'b0;
            rx.o_align_err <= 1'b0;
        end else begin
            state          <= state_n;
            zcnt           <= zcnt_n;
            run            <= run_n;
            bitcnt         <= bitcnt_n;
            shreg          <= shreg_n;
            data           <= data_n;
            first          <= first_n;
            rx.o_valid     <= valid_n;
            rx.o_sop       <= sop_n;
            rx.o_eop       <= eop_n;
            rx.o_stuff_err <= stuff_n;
            rx.o_sync_err  <= sync_n;
            rx.o_align_err <= align_n;
        end
    end

    assign rx.o_data = data;

endmodule
